// File: rtl/counter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// counter_ctrl_pkg
// Shared definitions for the event-counter front end: count-key FSM state
// encoding, default parameter values and the synchroniser depth.
// No ports (package).
// -----------------------------------------------------------------------------
package counter_ctrl_pkg;

   // Count-key FSM state encoding (2-bit, legacy-compatible constants)
   typedef logic [1:0] key_state_t;

   localparam key_state_t ST_IDLE   = 2'd0;
   localparam key_state_t ST_HOLD   = 2'd1;
   localparam key_state_t ST_REPEAT = 2'd2;

   // Flops in each input synchroniser chain
   localparam int unsigned SYNC_DEPTH = 2;

   // Default parameter values
   localparam int unsigned DB_CYCLES_DEF     = 16;
   localparam int unsigned HOLD_CYCLES_DEF   = 64;
   localparam int unsigned REPEAT_CYCLES_DEF = 16;
   localparam int unsigned REPEAT_EN_DEF     = 1;
   localparam int unsigned CNT_W_DEF         = 16;

endpackage

// File: rtl/counter_input_conditioner_if.sv
// -----------------------------------------------------------------------------
// counter_input_conditioner_if
// Bundles the raw push-button lines and the conditioned control outputs.
//   raw_key  : asynchronous count button, high = pressed
//   raw_mode : asynchronous mode button, high = pressed
//   en       : one-cycle count-enable pulse
//   sel      : mode select level (0 = count mode, 1 = alternate mode)
//   key_db   : debounced count-key level (debug)
//   mode_db  : debounced mode-key level (debug)
// master drives the buttons and observes the outputs; slave is the conditioner.
// -----------------------------------------------------------------------------
interface counter_input_conditioner_if;

   logic raw_key;
   logic raw_mode;
   logic en;
   logic sel;
   logic key_db;
   logic mode_db;

   modport master (
      output raw_key,
      output raw_mode,
      input  en,
      input  sel,
      input  key_db,
      input  mode_db
   );

   modport slave (
      input  raw_key,
      input  raw_mode,
      output en,
      output sel,
      output key_db,
      output mode_db
   );

endinterface

// File: rtl/debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
// Synchronises one asynchronous button line, then debounces it: the debounced
// level flips only after DB_CYCLES consecutive synchronised samples disagree
// with it.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   raw   : asynchronous button input
//   level : debounced level (registered)
//   rise  : one-cycle strobe, high in the first cycle that level is 1
// -----------------------------------------------------------------------------
module debounce_sync
   import counter_ctrl_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [SYNC_DEPTH-1:0] sync_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_d;
   logic                  level_q;
   logic                  rise_q;
   logic                  synced;
   logic                  flip;

   assign synced = sync_q[SYNC_DEPTH-1];

   // The current sample is the DB_CYCLES-th consecutive mismatch
   assign flip = (synced != level_q) && (cnt_q == DB_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (synced == level_q || flip) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_DEPTH-2:0], raw};
         cnt_q   <= cnt_d;
         if (flip) begin
            level_q <= ~level_q;
         end
         // Strobe registered alongside the level so it lines up with level=1
         rise_q  <= flip & ~level_q;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;

endmodule

// File: rtl/counter_input_conditioner.sv
// -----------------------------------------------------------------------------
// counter_input_conditioner
// Front end of the two-mode event counter. Turns the bouncing count and mode
// buttons into a clean one-cycle count-enable pulse (with optional auto-repeat
// while the count key is held) and a mode-select level that toggles on every
// mode-key press.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : counter_input_conditioner_if.slave
//           in  raw_key, raw_mode
//           out en, sel, key_db, mode_db
// -----------------------------------------------------------------------------
module counter_input_conditioner
   import counter_ctrl_pkg::*;
#(
   parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF,
   parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
   parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
   parameter int unsigned REPEAT_EN     = REPEAT_EN_DEF,
   parameter int unsigned CNT_W         = CNT_W_DEF
) (
   input  logic                         clk,
   input  logic                         reset,
   counter_input_conditioner_if.slave   bus
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic key_level;
   logic key_rise;
   logic mode_level;
   logic mode_rise;

   key_state_t       state_q;
   key_state_t       state_d;
   logic [CNT_W-1:0] hold_q;
   logic [CNT_W-1:0] hold_d;
   logic [CNT_W-1:0] rep_q;
   logic [CNT_W-1:0] rep_d;
   logic             en_q;
   logic             en_d;
   logic             sel_q;
   logic             sel_d;
   logic             pending_q;
   logic             pending_d;
   logic             toggle_req;

   debounce_sync #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
   ) u_key_db (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.raw_key),
      .level (key_level),
      .rise  (key_rise)
   );

   debounce_sync #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
   ) u_mode_db (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.raw_mode),
      .level (mode_level),
      .rise  (mode_rise)
   );

   // Count-key FSM: first pulse on press, optional auto-repeat while held
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      rep_d   = rep_q;
      en_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (key_rise) begin
               en_d    = 1'b1;
               hold_d  = '0;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!key_level) begin
               state_d = ST_IDLE;
            end else if (hold_q == HOLD_LAST) begin
               // Without auto-repeat the counter parks here until release
               if (REPEAT_EN != 0) begin
                  en_d    = 1'b1;
                  rep_d   = '0;
                  state_d = ST_REPEAT;
               end
            end else begin
               hold_d = hold_q + CNT_ONE;
            end
         end
         ST_REPEAT: begin
            if (!key_level) begin
               state_d = ST_IDLE;
            end else if (rep_q == REP_LAST) begin
               en_d  = 1'b1;
               rep_d = '0;
            end else begin
               rep_d = rep_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Mode toggle. A toggle that would land on the same edge as an en pulse is
   // held back one cycle so that pulse is counted under the old mode. en is
   // never high two cycles running, so a deferred toggle always retires on
   // the next edge and only one can be pending.
   assign toggle_req = mode_rise | pending_q;

   always_comb begin
      sel_d     = sel_q;
      pending_d = pending_q;
      if (toggle_req) begin
         if (en_d) begin
            pending_d = 1'b1;
         end else begin
            sel_d     = ~sel_q;
            pending_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         hold_q    <= '0;
         rep_q     <= '0;
         en_q      <= 1'b0;
         sel_q     <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         rep_q     <= rep_d;
         en_q      <= en_d;
         sel_q     <= sel_d;
         pending_q <= pending_d;
      end
   end

   assign bus.en      = en_q;
   assign bus.sel     = sel_q;
   assign bus.key_db  = key_level;
   assign bus.mode_db = mode_level;

endmodule

// File: tb/tb_counter_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_counter_input_conditioner
// Directed bench for counter_input_conditioner. Two instances share the same
// button stimulus: dut_a without auto-repeat, dut_b with it (DB=4, HOLD=8,
// REPEAT=3). Edge numbers follow the convention that edge 1 is the first edge
// sampling a new input level; per-edge output histories are compared against
// hand-computed bit masks.
// -----------------------------------------------------------------------------
module tb_counter_input_conditioner;

   logic clk = 1'b0;
   logic reset;
   logic raw_key;
   logic raw_mode;

   always #5 clk = ~clk;

   counter_input_conditioner_if bus_a ();
   counter_input_conditioner_if bus_b ();

   assign bus_a.raw_key  = raw_key;
   assign bus_a.raw_mode = raw_mode;
   assign bus_b.raw_key  = raw_key;
   assign bus_b.raw_mode = raw_mode;

   counter_input_conditioner #(
      .DB_CYCLES     (4),
      .HOLD_CYCLES   (8),
      .REPEAT_CYCLES (3),
      .REPEAT_EN     (0),
      .CNT_W         (8)
   ) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   counter_input_conditioner #(
      .DB_CYCLES     (4),
      .HOLD_CYCLES   (8),
      .REPEAT_CYCLES (3),
      .REPEAT_EN     (1),
      .CNT_W         (8)
   ) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   int vectors     = 0;
   int miscompares = 0;
   int edge_n      = 0;

   logic [127:0] en_a_h;
   logic [127:0] en_b_h;
   logic [127:0] kdb_h;
   logic [127:0] mdb_h;
   logic [127:0] sel_h;
   logic [127:0] exp_v;

   // One clock edge; sample outputs 1 time unit later and log them by edge
   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
      if (edge_n < 128) begin
         en_a_h[edge_n] = bus_a.en;
         en_b_h[edge_n] = bus_b.en;
         kdb_h[edge_n]  = bus_a.key_db;
         mdb_h[edge_n]  = bus_a.mode_db;
         sel_h[edge_n]  = bus_a.sel;
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic clear_hist();
      edge_n = 0;
      en_a_h = '0;
      en_b_h = '0;
      kdb_h  = '0;
      mdb_h  = '0;
      sel_h  = '0;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] span(input int lo, input int hi);
      logic [127:0] v = '0;
      for (int i = lo; i <= hi; i++) v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [127:0] all_outs();
      return {120'd0, bus_a.en, bus_a.sel, bus_a.key_db, bus_a.mode_db,
              bus_b.en, bus_b.sel, bus_b.key_db, bus_b.mode_db};
   endfunction

   task automatic do_reset(input string tag);
      reset    = 1'b1;
      raw_key  = 1'b0;
      raw_mode = 1'b0;
      ticks(3);
      check(tag, all_outs(), '0);
      reset = 1'b0;
      clear_hist();
   endtask

   initial begin
      reset    = 1'b1;
      raw_key  = 1'b0;
      raw_mode = 1'b0;
      clear_hist();

      // ---- Clean press held 30 cycles, then released -------------------
      do_reset("reset_values");
      raw_key = 1'b1;
      ticks(30);
      raw_key = 1'b0;
      ticks(20);
      check("clean_en_single", en_a_h, span(7, 7));
      check("clean_key_db", kdb_h, span(6, 35));
      exp_v = span(7, 7) | span(15, 15);
      for (int k = 18; k <= 36; k += 3) exp_v[k] = 1'b1;
      check("repeat_en_train", en_b_h, exp_v);
      check("repeat_no_back_to_back", en_b_h & (en_b_h >> 1), '0);
      check("clean_sel_quiet", sel_h, '0);

      // ---- Bounce: 1,0,1,1,0 then steady high from edge 6 --------------
      do_reset("reset_before_bounce");
      raw_key = 1'b1; tick();
      raw_key = 1'b0; tick();
      raw_key = 1'b1; tick();
      raw_key = 1'b1; tick();
      raw_key = 1'b0; tick();
      raw_key = 1'b1;
      ticks(20);
      raw_key = 1'b0;
      ticks(15);
      check("bounce_en_single", en_a_h, span(12, 12));
      check("bounce_key_db", kdb_h, span(11, 30));
      exp_v = span(12, 12) | span(20, 20) | span(23, 23) | span(26, 26) | span(29, 29);
      check("bounce_repeat", en_b_h, exp_v);

      // ---- Three mode presses starting at edges 1, 23, 45 --------------
      do_reset("reset_before_mode");
      for (int p = 0; p < 3; p++) begin
         raw_mode = 1'b1;
         ticks(10);
         raw_mode = 1'b0;
         ticks(12);
      end
      ticks(10);
      check("mode_sel_seq", sel_h, span(7, 28) | span(51, 76));
      check("mode_db_level", mdb_h, span(6, 15) | span(28, 37) | span(50, 59));
      check("mode_no_en", en_a_h, '0);

      // ---- Key and mode pressed on the same edge -----------------------
      do_reset("reset_before_coincide");
      raw_key  = 1'b1;
      raw_mode = 1'b1;
      ticks(20);
      raw_key  = 1'b0;
      raw_mode = 1'b0;
      ticks(15);
      check("coincide_en", en_a_h, span(7, 7));
      check("coincide_sel_deferred", sel_h, span(8, 35));

      // ---- Reset while dut_b is auto-repeating, key still held ---------
      do_reset("reset_before_midhold");
      raw_key = 1'b1;
      ticks(20);
      check("midhold_pre_train", en_b_h, span(7, 7) | span(15, 15) | span(18, 18));
      reset = 1'b1;
      ticks(2);
      check("midhold_reset_outputs", all_outs(), '0);
      reset = 1'b0;
      clear_hist();
      ticks(20);
      check("midhold_fresh_a", en_a_h, span(7, 7));
      check("midhold_fresh_b", en_b_h, span(7, 7) | span(15, 15) | span(18, 18));
      check("midhold_key_db", kdb_h, span(6, 20));
      raw_key = 1'b0;
      ticks(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/counter_input_conditioner.md
# counter_input_conditioner

Front-end stage feeding the two-mode event counter. It turns two asynchronous, bouncing push-button lines into clean control: a single-cycle count-enable pulse `en` (with optional auto-repeat while held) and a level mode select `sel` that toggles on each mode-button press. It synchronises, debounces and edge-detects both inputs so that the downstream counter sees exactly one `en` pulse per intended press.

## Interface
- `DB_CYCLES`, 16: consecutive stable synchronised samples required before a debounced level flips; must be ≥ 2.
- `HOLD_CYCLES`, 64: cycles the count key must stay held after its first pulse before auto-repeat starts.
- `REPEAT_CYCLES`, 16: period of auto-repeat `en` pulses; must be ≥ 2.
- `REPEAT_EN`, 1: 1 enables auto-repeat; 0 gives exactly one pulse per press.
- `CNT_W`, 16: width of the internal debounce, hold and repeat counters; must hold max(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES).
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `raw_key`  in  1: asynchronous count button, high = pressed.
- `raw_mode`  in  1: asynchronous mode button, high = pressed.
- `en`  out  1: registered count-enable pulse, one cycle wide per event.
- `sel`  out  1: registered mode select; 0 = count mode, 1 = alternate mode.
- `key_db`  out  1: debounced count-key level (debug).
- `mode_db`  out  1: debounced mode-key level (debug).

## Operation
- Each raw input passes through a 2-flop synchroniser. Then a debouncer holds a debounced level and a mismatch counter.
  - Synced level equals the debounced level: the counter clears.
  - Otherwise it increments.
  - When the counter equals DB_CYCLES-1 and the mismatch persists, the debounced level flips and the counter clears.
- A glitch shorter than DB_CYCLES synced cycles never changes the debounced level.
- Count-key FSM, states IDLE, HOLD, REPEAT:
  - IDLE: on a `key_db` rising edge, emit `en` and go to HOLD. The hold counter clears.
  - HOLD: on `key_db`=0, go to IDLE. When the hold counter reaches HOLD_CYCLES-1 with REPEAT_EN=1, emit `en` and go to REPEAT with the repeat counter cleared. With REPEAT_EN=0, stay in HOLD until release.
  - REPEAT: on `key_db`=0, go to IDLE with no pulse. Every REPEAT_CYCLES cycles, emit `en`.
- Mode path: each `mode_db` rising edge toggles `sel`. Releasing the mode key has no effect.
- Coincidence rule: if a `sel` toggle and an `en` pulse would register on the same edge, the toggle is deferred one cycle. The pulse is then counted under the old mode. At most one deferred toggle is pending at a time.
- Reset values:
  - `en`=0, `sel`=0, `key_db`=0, `mode_db`=0.
  - Synchronisers 0, all counters 0, FSM IDLE, pending toggle cleared.
- Reset mid-press: state is lost. A button still held after reset deasserts is re-debounced from 0, so it produces a fresh first pulse (and mode toggle).

## Timing
- Edge n is numbered from the first edge that samples `raw_key`=1, counted as edge 1.
  - Synced level is 1 after edge 2.
  - `key_db` rises after edge DB_CYCLES+2.
  - `en` is high for exactly the cycle after edge DB_CYCLES+3.
- Release latency is symmetric: `key_db` falls DB_CYCLES+2 edges after the first low sample.
- First repeat pulse: HOLD_CYCLES cycles after the first pulse. Subsequent pulses: every REPEAT_CYCLES cycles.
- `sel` toggles DB_CYCLES+3 edges after the first high `raw_mode` sample, or +1 edge when the toggle is deferred.
- `en` is never high on two consecutive cycles.

## Structure
- Shared package `counter_ctrl_pkg` holds:
  - the FSM state typedef (IDLE/HOLD/REPEAT, 2-bit);
  - default parameter constants;
  - the synchroniser depth constant (2).
- Natural sub-module: `debounce_sync`, instantiated twice. It contains the synchroniser, debounce counter and debounced level, and outputs the level plus a one-cycle rise strobe.
- The top level holds the count FSM, the mode toggle and the coincidence logic.

## Test plan
- Clean press, DB_CYCLES=4, REPEAT_EN=0: `raw_key` high for 20 cycles. Expect `en` high only in the cycle after edge 7, and `key_db` high from edge 6.
- Bounce, DB_CYCLES=4: `raw_key` toggles 1,0,1,1,0 then stays high. Expect exactly one `en` pulse, 7 edges after the last 0→1 transition.
- Auto-repeat, DB=4, HOLD=8, REPEAT=3: hold for 30 cycles. Expect pulses at edges 7, 15, 18, 21, …; none after `key_db` falls.
- Mode toggle: three `raw_mode` presses. Expect `sel` sequence 0→1→0→1, each change 7 edges after its press start. Release causes no change.
- Coincidence: align a key press and a mode press to the same edge. Expect `en` at edge 7 with `sel`=0, and `sel`=1 from edge 8.
- Reset mid-hold: assert `reset` in the REPEAT state while `raw_key` stays high. Expect all outputs 0 during reset, then a fresh first `en` DB_CYCLES+3 edges after reset drops.
